i2c_scl_gen: RTL and testbench

- Parametrised successor to the fixed 400 kHz SCL clock generator.
- Produces the open-drain SCL enable from CLK (156.25 MHz) with a runtime-selectable half-period.
- Supports clock stretching, with SCL read back through a 2-flop synchroniser, and a stretch timeout.
- Emits phase ticks (fall, rise, mid-low, mid-high) so the I2C byte/bit engine can change SDA mid-low and sample it mid-high.

---
 rtl/i2c_scl_gen.sv | 150 +++++++++++++++
 tb/tb_i2c_scl_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_scl_gen.sv
// Open-drain I2C SCL generator with runtime half-period, clock stretching,
// stretch timeout and phase ticks for the SDA bit engine.
module i2c_scl_gen #(
    parameter int CLK_HZ       = 156250000,
    parameter int SCL_HZ       = 400000,
    parameter int CNT_W        = 12,
    parameter int DEFAULT_HALF = CLK_HZ / (2 * SCL_HZ),
    parameter int TIMEOUT_CYC  = 16384
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    input  logic             scl_in,
    output logic             scl_t,
    output logic             busy,
    output logic             fall_tick,
    output logic             rise_tick,
    output logic             mid_low,
    output logic             mid_high,
    output logic             stretch,
    output logic             timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    localparam int SW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] DEF_HALF =
        CNT_W'((DEFAULT_HALF != 0) ? DEFAULT_HALF : CLK_HZ / (2 * SCL_HZ));
    localparam logic [SW-1:0]    TO_LAST  = SW'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] half_lat, half_n;
    logic [SW-1:0]    scnt, scnt_n;
    logic [1:0]       sync_q;
    logic             rise_seen, seen_n;
    logic             fall_n, tout_n;
    logic             past2;

    function automatic logic [CNT_W-1:0] eff_half(input logic [CNT_W-1:0] d);
        if (d == '0)
            return DEF_HALF;
        else if (d == CNT_W'(1))
            return TWO;
        else
            return d;
    endfunction

    assign past2 = (cnt >= TWO);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        half_n  = half_lat;
        scnt_n  = scnt;
        seen_n  = rise_seen;
        fall_n  = 1'b0;
        tout_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) begin
                    state_n = S_LOW;
                    cnt_n   = '0;
                    half_n  = eff_half(div);
                    fall_n  = 1'b1;
                end
            end
            S_LOW: begin
                if (cnt == half_lat - 1'b1) begin
                    state_n = S_HIGH;
                    cnt_n   = '0;
                    scnt_n  = '0;
                    seen_n  = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_HIGH: begin
                if (past2 && sync_q[1])
                    seen_n = 1'b1;
                // The first two HIGH cycles ignore the pin: the synchroniser
                // still shows the level we were driving.
                if (past2 && !sync_q[1]) begin
                    scnt_n = scnt + 1'b1;
                    if (scnt == TO_LAST) begin
                        state_n = S_HALT;
                        tout_n  = 1'b1;
                    end
                end else if (cnt == half_lat - 1'b1) begin
                    cnt_n = '0;
                    if (en) begin
                        state_n = S_LOW;
                        half_n  = eff_half(div);
                        fall_n  = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                if (!en)
                    state_n = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values; sync_q[0] is the
    // scl_sync value the next cycle will see.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            cnt       <= '0;
            half_lat  <= '0;
            scnt      <= '0;
            sync_q    <= 2'b11;
            rise_seen <= 1'b0;
            scl_t     <= 1'b1;
            busy      <= 1'b0;
            fall_tick <= 1'b0;
            rise_tick <= 1'b0;
            mid_low   <= 1'b0;
            mid_high  <= 1'b0;
            stretch   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            half_lat  <= half_n;
            scnt      <= scnt_n;
            sync_q    <= {sync_q[0], scl_in};
            rise_seen <= seen_n;
            scl_t     <= (state_n != S_LOW);
            busy      <= (state_n != S_IDLE);
            fall_tick <= fall_n;
            timeout   <= tout_n;
            rise_tick <= (state_n == S_HIGH) && (cnt_n >= TWO) && sync_q[0] && !seen_n;
            mid_high  <= (state_n == S_HIGH) && (cnt_n == (half_n >> 1)) && sync_q[0];
            mid_low   <= (state_n == S_LOW) && (cnt_n == (half_n >> 1));
            stretch   <= (state_n == S_HIGH) && (cnt_n >= TWO) && !sync_q[0];
        end
    end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Bench for i2c_scl_gen: phase-level reference model checked every cycle,
// plus directed timing measurements for rate, stretch, timeout, stop, reset.
module tb_i2c_scl_gen;

    localparam int CNT_W       = 12;
    localparam int TIMEOUT_CYC = 16384;
    localparam int DEF_HALF    = 195;

    localparam int PH_IDLE = 0, PH_LOW = 1, PH_HIGH = 2, PH_HALT = 3;
    localparam int SG_FALL = 0, SG_RISE = 1, SG_MLOW = 2, SG_MHIGH = 3, SG_STR = 4,
                   SG_TOUT = 5, SG_SCLT = 6, SG_BUSY = 7, SG_IDLE = 8, NSIG = 9;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             en = 1'b0;
    logic             hold = 1'b0;
    logic [CNT_W-1:0] div = '0;
    logic             scl_in;
    logic             scl_t, busy, fall_tick, rise_tick, mid_low, mid_high, stretch, timeout;

    // Open-drain pin: released level follows scl_t unless the "slave" holds it low.
    assign scl_in = scl_t & ~hold;

    always #5 CLK = ~CLK;

    i2c_scl_gen dut (
        .CLK(CLK), .RST_N(RST_N), .en(en), .div(div), .scl_in(scl_in),
        .scl_t(scl_t), .busy(busy), .fall_tick(fall_tick), .rise_tick(rise_tick),
        .mid_low(mid_low), .mid_high(mid_high), .stretch(stretch), .timeout(timeout)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: phase, position within phase, stalled-cycle count.
    int m_ph, m_pos, m_half, m_stall;
    bit m_rose, m_sync, m_p1, m_fall, m_tout;

    function automatic int eff(input int d);
        return (d == 0) ? DEF_HALF : ((d == 1) ? 2 : d);
    endfunction

    function automatic logic [7:0] model_out();
        bit hi;
        hi = (m_ph == PH_HIGH);
        return {m_fall,
                hi && m_pos >= 2 && m_sync && !m_rose,
                (m_ph == PH_LOW) && (m_pos == m_half / 2),
                hi && (m_pos == m_half / 2) && m_sync,
                hi && m_pos >= 2 && !m_sync,
                m_tout,
                m_ph != PH_LOW,
                m_ph != PH_IDLE};
    endfunction

    task automatic model_reset();
        m_ph = PH_IDLE; m_pos = 0; m_half = 0; m_stall = 0;
        m_rose = 0; m_sync = 1; m_p1 = 1; m_fall = 0; m_tout = 0;
    endtask

    task automatic model_step();
        if (m_ph == PH_HIGH && m_pos >= 2 && m_sync) m_rose = 1;
        m_fall = 0;
        m_tout = 0;
        case (m_ph)
            PH_IDLE: if (en) begin m_ph = PH_LOW; m_pos = 0; m_half = eff(int'(div)); m_fall = 1; end
            PH_LOW: begin
                if (m_pos == m_half - 1) begin
                    m_ph = PH_HIGH; m_pos = 0; m_stall = 0; m_rose = 0;
                end else m_pos++;
            end
            PH_HIGH: begin
                if (m_pos >= 2 && !m_sync) begin
                    m_stall++;
                    if (m_stall == TIMEOUT_CYC) begin m_ph = PH_HALT; m_tout = 1; end
                end else if (m_pos == m_half - 1) begin
                    m_pos = 0;
                    if (en) begin m_ph = PH_LOW; m_half = eff(int'(div)); m_fall = 1; end
                    else m_ph = PH_IDLE;
                end else m_pos++;
            end
            default: if (!en) m_ph = PH_IDLE;
        endcase
        m_sync = m_p1;
        m_p1   = scl_in;
    endtask

    // Per-cycle comparison against the model; inputs are stable at negedge.
    always @(negedge CLK) begin
        logic [7:0] exp_v, act_v;
        if (!RST_N) model_reset();
        exp_v = model_out();
        act_v = {fall_tick, rise_tick, mid_low, mid_high, stretch, timeout, scl_t, busy};
        n_chk++;
        if (act_v == exp_v) n_pass++;
        else $display("FAIL cycle_model @%0t: got %b, expected %b", $time, act_v, exp_v);
        if (RST_N) model_step();
    end

    // Directed measurements: first-occurrence offset and count per signal.
    int first [NSIG];
    int cnt   [NSIG];
    int ofs;

    function automatic bit sig(input int i);
        case (i)
            SG_FALL:  return fall_tick;
            SG_RISE:  return rise_tick;
            SG_MLOW:  return mid_low;
            SG_MHIGH: return mid_high;
            SG_STR:   return stretch;
            SG_TOUT:  return timeout;
            SG_SCLT:  return scl_t;
            SG_BUSY:  return busy;
            default:  return !busy;
        endcase
    endfunction

    task automatic clear_obs();
        ofs = 0;
        for (int i = 0; i < NSIG; i++) begin first[i] = -1; cnt[i] = 0; end
    endtask

    task automatic observe(input int n);
        repeat (n) begin
            @(posedge CLK); #2;
            ofs++;
            for (int i = 0; i < NSIG; i++)
                if (sig(i)) begin
                    cnt[i]++;
                    if (first[i] < 0) first[i] = ofs;
                end
        end
    endtask

    initial begin
        int r;
        repeat (3) @(posedge CLK);
        #2;
        chk("reset_scl_t", scl_t, 1);
        chk("reset_busy", busy, 0);
        chk("reset_fall", fall_tick, 0);

        // Default rate with scl_in following scl_t
        RST_N = 1'b1; en = 1'b1;
        clear_obs(); observe(1);
        chk("first_fall", first[SG_FALL], 1);
        clear_obs(); observe(390);
        chk("dflt_mid_low", first[SG_MLOW], 97);
        chk("dflt_scl_rise", first[SG_SCLT], 195);
        chk("dflt_rise_tick", first[SG_RISE], 197);
        chk("dflt_mid_high", first[SG_MHIGH], 292);
        chk("dflt_period", first[SG_FALL], 390);
        chk("dflt_high_cycles", cnt[SG_SCLT], 195);
        chk("dflt_mid_low_cnt", cnt[SG_MLOW], 1);

        // Rate change mid-LOW takes effect at the next fall
        clear_obs(); observe(50);
        div = 12'd781;
        observe(340);
        chk("chg_old_period", first[SG_FALL], 390);
        clear_obs(); observe(1562);
        chk("slow_period", first[SG_FALL], 1562);
        chk("slow_high_cycles", cnt[SG_SCLT], 781);
        chk("slow_mid_low", first[SG_MLOW], 390);
        div = 12'd1;
        clear_obs(); observe(1562);
        chk("slow_period2", first[SG_FALL], 1562);
        clear_obs(); observe(4);
        chk("clamp_period", first[SG_FALL], 4);
        chk("clamp_high", cnt[SG_SCLT], 2);
        div = 12'd0;
        clear_obs(); observe(4);
        chk("back_to_dflt", first[SG_FALL], 4);

        // Stretch: slave holds SCL low for 1000 cycles after release
        clear_obs(); observe(195);
        chk("str_release", first[SG_SCLT], 195);
        hold = 1'b1; observe(1000);
        hold = 1'b0; observe(195);
        chk("str_first", first[SG_STR], 197);
        chk("str_len", cnt[SG_STR], 1000);
        chk("str_rise", first[SG_RISE], 1197);
        chk("str_fall", first[SG_FALL], 1390);
        chk("str_no_tout", cnt[SG_TOUT], 0);

        // Timeout: SCL stuck low
        hold = 1'b1;
        clear_obs(); observe(16586);
        chk("to_stretch_start", first[SG_STR], 197);
        chk("to_pulse", first[SG_TOUT], 197 + TIMEOUT_CYC);
        chk("to_count", cnt[SG_TOUT], 1);
        chk("halt_scl_t", scl_t, 1);
        chk("halt_busy", busy, 1);
        clear_obs(); observe(50);
        chk("halt_no_fall", cnt[SG_FALL], 0);
        chk("halt_stays_busy", cnt[SG_IDLE], 0);
        en = 1'b0;
        clear_obs(); observe(2);
        chk("halt_exit", first[SG_IDLE], 1);
        hold = 1'b0; en = 1'b1;
        clear_obs(); observe(1);
        chk("rearm_fall", first[SG_FALL], 1);

        // Graceful stop 50 cycles into LOW
        clear_obs(); observe(50);
        en = 1'b0;
        observe(450);
        chk("stop_scl_rise", first[SG_SCLT], 195);
        chk("stop_mid_high", cnt[SG_MHIGH], 1);
        chk("stop_idle", first[SG_IDLE], 390);
        chk("stop_no_fall", cnt[SG_FALL], 0);
        chk("stop_scl_t", scl_t, 1);

        // Async reset between edges, mid-LOW
        en = 1'b1;
        clear_obs(); observe(31);
        chk("pre_rst_scl_t", scl_t, 0);
        RST_N = 1'b0;
        #1;
        chk("async_scl_t", scl_t, 1);
        chk("async_busy", busy, 0);
        @(posedge CLK); #2;
        RST_N = 1'b1;
        clear_obs(); observe(1);
        chk("post_rst_fall", first[SG_FALL], 1);

        // Random rates, en toggles and stretch bursts against the model
        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(0, 9);
            div = (r == 0) ? 12'd0 : ((r == 1) ? 12'd1 : CNT_W'($urandom_range(2, 40)));
            en = ($urandom_range(0, 4) != 0);
            repeat ($urandom_range(10, 200)) begin
                if ($urandom_range(0, 15) == 0) hold = ~hold;
                observe(1);
            end
        end
        hold = 1'b0; en = 1'b0;
        observe(500);
        chk("final_idle", busy, 0);
        chk("final_scl_t", scl_t, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
